// File: rtl/mod5_serial_encoder.sv
// mod5_serial_encoder
// Bit-serial transmitter for the divisible-by-5 residue check. It takes a
// WIDTH-bit payload and sends it MSB-first. It then appends a 3-bit check
// value C, chosen so that the (WIDTH+3)-bit frame is a multiple of 5.
//
// Optional build macro: MOD5_ERR_INJECT_EN.
// Defining it adds the err_inject input. A frame accepted with err_inject=1
// carries (C+1) mod 5 as its check value, which makes that frame a
// deliberately bad one for exercising the downstream checker.

module mod5_serial_encoder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
`ifdef MOD5_ERR_INJECT_EN
   input  logic             err_inject,
`endif
   output logic             ser_out,
   output logic             ser_valid,
   output logic             ser_first,
   output logic             ser_last
);

   // The counter indexes payload bits (0..WIDTH-1) and check bits (0..2).
   localparam int CNT_W = $clog2(WIDTH + 3);
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      CHECK = 2'd2
   } state_t;

   // One residue step: r' = (2r + b) mod 5. Input range 0..4 gives 2r+b in 0..9.
   function automatic logic [2:0] mod5_step(input logic [2:0] r, input logic b);
      logic [3:0] v;
      v = {r, b};
      if (v >= 4'd5) begin
         return 3'(v - 4'd5);
      end
      return v[2:0];
   endfunction

   // Check value that makes (payload * 8 + C) a multiple of 5. Because
   // 8 = 3 (mod 5), C = (5 - 3r) mod 5. An injected error adds 1 mod 5.
   function automatic logic [2:0] check_value(input logic [2:0] r, input logic inj);
      logic [2:0] c;
      case (r)
         3'd0:    c = 3'd0;
         3'd1:    c = 3'd2;
         3'd2:    c = 3'd4;
         3'd3:    c = 3'd1;
         3'd4:    c = 3'd3;
         default: c = 3'd0;
      endcase
      if (inj) begin
         c = (c == 3'd4) ? 3'd0 : c + 3'd1;
      end
      return c;
   endfunction

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       residue_q, residue_d;
   logic [2:0]       check_q, check_d;
   logic             ser_out_d, ser_valid_d, ser_first_d, ser_last_d;
   logic             inject_q, inject_d;
   logic             inject_in;
   logic             take;

`ifdef MOD5_ERR_INJECT_EN
   assign inject_in = err_inject;
`else
   assign inject_in = 1'b0;
`endif

   // Accept a word when idle, or on the final check bit so frames run back-to-back.
   always_comb begin
      in_ready = (state_q == IDLE) || ((state_q == CHECK) && (cnt_q == CNT_W'(2)));
      take     = in_valid && in_ready;
   end

   // Next-state and next-output logic for the IDLE -> DATA -> CHECK sequence.
   always_comb begin
      // NOTE: every signal gets a default before the case. A path that leaves
      // one unassigned would infer a latch. Blocking '=' is correct here.
      state_d     = state_q;
      shift_d     = shift_q;
      cnt_d       = cnt_q;
      residue_d   = residue_q;
      check_d     = check_q;
      inject_d    = inject_q;
      ser_out_d   = 1'b0;
      ser_valid_d = 1'b0;
      ser_first_d = 1'b0;
      ser_last_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (take) begin
               state_d     = DATA;
               cnt_d       = '0;
               residue_d   = '0;
               inject_d    = inject_in;
               shift_d     = in_data << 1;
               ser_out_d   = in_data[WIDTH-1];
               ser_valid_d = 1'b1;
               ser_first_d = 1'b1;
            end
         end

         DATA: begin
            // Fold the bit currently on the wire into the running residue.
            residue_d   = mod5_step(residue_q, ser_out);
            ser_valid_d = 1'b1;
            if (cnt_q == LAST_DATA) begin
               state_d   = CHECK;
               cnt_d     = '0;
               check_d   = check_value(residue_d, inject_q);
               ser_out_d = check_d[2];
            end else begin
               cnt_d     = cnt_q + CNT_W'(1);
               ser_out_d = shift_q[WIDTH-1];
               shift_d   = shift_q << 1;
            end
         end

         CHECK: begin
            if (cnt_q == CNT_W'(0)) begin
               cnt_d       = CNT_W'(1);
               ser_out_d   = check_q[1];
               ser_valid_d = 1'b1;
            end else if (cnt_q == CNT_W'(1)) begin
               cnt_d       = CNT_W'(2);
               ser_out_d   = check_q[0];
               ser_valid_d = 1'b1;
               ser_last_d  = 1'b1;
            end else if (take) begin
               // A new word arrives on the last check bit: start it with no gap.
               state_d     = DATA;
               cnt_d       = '0;
               residue_d   = '0;
               inject_d    = inject_in;
               shift_d     = in_data << 1;
               ser_out_d   = in_data[WIDTH-1];
               ser_valid_d = 1'b1;
               ser_first_d = 1'b1;
            end else begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State register. An asynchronous reset aborts any frame in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking '<=' so every register
      // samples its pre-edge value, regardless of statement order.
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and registered serial outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q   <= '0;
         cnt_q     <= '0;
         residue_q <= '0;
         check_q   <= '0;
         inject_q  <= 1'b0;
         ser_out   <= 1'b0;
         ser_valid <= 1'b0;
         ser_first <= 1'b0;
         ser_last  <= 1'b0;
      end else begin
         shift_q   <= shift_d;
         cnt_q     <= cnt_d;
         residue_q <= residue_d;
         check_q   <= check_d;
         inject_q  <= inject_d;
         ser_out   <= ser_out_d;
         ser_valid <= ser_valid_d;
         ser_first <= ser_first_d;
         ser_last  <= ser_last_d;
      end
   end

   // Invariants of the residue arithmetic and the framing outputs.
   a_residue_range : assert property (@(posedge clk) disable iff (!rst_n)
      residue_q <= 3'd4);
   a_check_range : assert property (@(posedge clk) disable iff (!rst_n)
      check_q <= 3'd4);
   a_first_last_excl : assert property (@(posedge clk) disable iff (!rst_n)
      !(ser_first && ser_last));
   a_idle_quiet : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == IDLE) |-> !ser_valid);

endmodule
